// File: rtl/daq_frame_packer.sv
// daq_frame_packer
// Packs the decimated signed sample stream into framed 32-bit AXI-stream packets.
// Each frame is {SYNC, seq, FRAME_LEN} followed by FRAME_LEN sign-extended samples.
// A first-word-fall-through sample FIFO decouples the decimator from downstream stalls.
module daq_frame_packer #(
    parameter int         DW         = 24,
    parameter int         FRAME_LEN  = 64,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] SYNC       = 8'hA5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic [DW-1:0] s_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic [31:0]   m_axis_tdata,
    output logic          m_axis_tlast
);

    localparam int            AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int            CW       = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [15:0]   FLEN16   = 16'(FRAME_LEN);
    localparam logic [15:0]   LAST_IDX = 16'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    // Sample storage carries no reset; only pointers and count define its contents.
    logic signed [DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;

    state_t               state;
    logic [7:0]           seq;
    logic [15:0]          idx;

    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 last_beat;
    logic signed [DW-1:0] head;

    // Size cast of a signed operand replicates the sign bit up to 32 bits.
    function automatic logic signed [31:0] sext32(input logic signed [DW-1:0] d);
        sext32 = 32'(d);
    endfunction

    assign full          = (count == DEPTH_C);
    assign empty         = (count == '0);
    assign s_axis_tready = !full;
    // A full FIFO refuses input even when a pop frees a slot in the same cycle.
    assign push          = s_axis_tvalid && !full;
    assign pop           = (state == PAYLOAD) && !empty && m_axis_tready;
    assign last_beat     = (idx == LAST_IDX);
    assign head          = mem[rd_ptr];

    // Sample write port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_axis_tdata;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of 2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Frame sequencer: header, then FRAME_LEN payload beats, then one idle cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            seq   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state <= HEADER;
                    end
                end
                HEADER: begin
                    if (m_axis_tready) begin
                        state <= PAYLOAD;
                        idx   <= '0;
                    end
                end
                PAYLOAD: begin
                    if (pop) begin
                        if (last_beat) begin
                            seq   <= seq + 8'd1;
                            idx   <= '0;
                            state <= IDLE;
                        end else begin
                            idx <= idx + 16'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode from state; payload valid follows FIFO occupancy so a starved frame pauses.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 32'h0;
        m_axis_tlast  = 1'b0;
        case (state)
            HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = {SYNC, seq, FLEN16};
            end
            PAYLOAD: begin
                m_axis_tvalid = !empty;
                m_axis_tdata  = sext32(head);
                m_axis_tlast  = last_beat;
            end
            default: begin
                m_axis_tvalid = 1'b0;
            end
        endcase
    end

endmodule
